mac_feeder: RTL and testbench

Sequencer that drives the operand side of the 4-bit MAC unit (clk, reset, A, B, accumulator) and reads its result back. Software-side logic loads two operand vectors into a small buffer and pulses start. The block clears the MAC, streams one operand pair per cycle, and captures the MAC accumulator. It returns the dot product on a valid/ready result port, with an overflow flag from a full-width shadow sum.

---
 rtl/mac_feeder_if.sv | 39 +++
 rtl/mac_feeder.sv | 150 +++++++++++++++
 tb/tb_mac_feeder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_feeder_if.sv
// mac_feeder_if: buffer load, run control, MAC operand and result bundle.
// master is the sequencer, slave is the host / MAC side.
interface mac_feeder_if #(
    parameter int DEPTH = 8,
    parameter int OPW   = 4,
    parameter int ACCW  = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
);
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [OPW-1:0]  wr_a;
    logic [OPW-1:0]  wr_b;
    logic            start;
    logic [LW-1:0]   len;
    logic            busy;
    logic            mac_clr;
    logic [OPW-1:0]  mac_a;
    logic [OPW-1:0]  mac_b;
    logic [ACCW-1:0] mac_acc;
    logic            res_valid;
    logic            res_ready;
    logic [ACCW-1:0] res_data;
    logic            res_ovf;

    modport master (
        input  wr_en, wr_addr, wr_a, wr_b, start, len,
        input  mac_acc, res_ready,
        output busy, mac_clr, mac_a, mac_b,
        output res_valid, res_data, res_ovf
    );

    modport slave (
        output wr_en, wr_addr, wr_a, wr_b, start, len,
        output mac_acc, res_ready,
        input  busy, mac_clr, mac_a, mac_b,
        input  res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/mac_feeder.sv
// mac_feeder: streams buffered operand pairs into a small MAC unit and
// returns its accumulator with a wide shadow sum for overflow detection.
module mac_feeder #(
    parameter int DEPTH = 8,
    parameter int OPW   = 4,
    parameter int ACCW  = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    mac_feeder_if.master bus
);
    localparam int SW = ACCW + AW + 1;
    localparam int PW = 2 * OPW;

    typedef enum logic [2:0] {
        IDLE, CLR, ISSUE, WAIT, HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [OPW-1:0]  buf_a_q [DEPTH];
    logic [OPW-1:0]  buf_a_d [DEPTH];
    logic [OPW-1:0]  buf_b_q [DEPTH];
    logic [OPW-1:0]  buf_b_d [DEPTH];
    logic [AW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   len_q, len_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic            busy_q, busy_d;
    logic            mac_clr_q, mac_clr_d;
    logic [OPW-1:0]  mac_a_q, mac_a_d;
    logic [OPW-1:0]  mac_b_q, mac_b_d;
    logic            res_valid_q, res_valid_d;
    logic [ACCW-1:0] res_data_q, res_data_d;
    logic            res_ovf_q, res_ovf_d;

    logic [PW-1:0]   prod;
    logic            last;

    assign prod = PW'(buf_a_q[idx_q]) * PW'(buf_b_q[idx_q]);
    assign last = (LW'(idx_q) == len_q - LW'(1));

    always_comb begin
        state_d    = state_q;
        buf_a_d    = buf_a_q;
        buf_b_d    = buf_b_q;
        idx_d      = idx_q;
        len_d      = len_q;
        sum_d      = sum_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;

        unique case (state_q)
            IDLE: begin
                // write lands before the run reads the buffer
                if (bus.wr_en) begin
                    buf_a_d[bus.wr_addr] = bus.wr_a;
                    buf_b_d[bus.wr_addr] = bus.wr_b;
                end
                if (bus.start) begin
                    if (bus.len == '0) begin
                        res_data_d = '0;
                        res_ovf_d  = 1'b0;
                        state_d    = HOLD;
                    end else begin
                        len_d   = (bus.len > LW'(DEPTH)) ?
                                  LW'(DEPTH) : bus.len;
                        state_d = CLR;
                    end
                end
            end
            CLR: begin
                sum_d   = '0;
                idx_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                sum_d = sum_q + SW'(prod);
                if (last) begin
                    state_d = WAIT;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            WAIT: begin
                res_data_d = bus.mac_acc;
                res_ovf_d  = |sum_q[SW-1:ACCW];
                state_d    = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        mac_clr_d   = (state_d == CLR);
        res_valid_d = (state_d == HOLD);
        mac_a_d     = '0;
        mac_b_d     = '0;
        if (state_d == ISSUE) begin
            mac_a_d = buf_a_q[idx_d];
            mac_b_d = buf_b_q[idx_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            busy_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_a_q[i] <= '0;
                buf_b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            busy_q      <= busy_d;
            mac_clr_q   <= mac_clr_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
            buf_a_q     <= buf_a_d;
            buf_b_q     <= buf_b_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed vectors for mac_feeder driving a behavioural
// 4-bit MAC, plus sequences for backpressure, guards, reset, back-to-back.
module tb_mac_feeder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] acc = '0;

    mac_feeder_if #(.DEPTH(8), .OPW(4), .ACCW(8)) bus ();

    mac_feeder #(.DEPTH(8), .OPW(4), .ACCW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural MAC: accumulates a*b each cycle, wraps mod 256
    always_ff @(posedge clk) begin
        if (bus.mac_clr) acc <= '0;
        else acc <= acc + ({4'b0, bus.mac_a} * {4'b0, bus.mac_b});
    end
    assign bus.mac_acc = acc;

    typedef struct {
        int a [8];
        int b [8];
        int len;
        int d;
        int o;
    } vec_t;

    vec_t vt [9];
    int ma [8];
    int mb [8];
    int basic_a [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    int basic_b [8] = '{5, 6, 7, 8, 0, 0, 0, 0};
    int zero8 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.busy, bus.mac_clr, bus.mac_a, bus.mac_b,
                     bus.res_valid, bus.res_data, bus.res_ovf});
    endfunction

    task automatic load();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'(i);
            bus.wr_a    = 4'(ma[i]);
            bus.wr_b    = 4'(mb[i]);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic run(input int len, input int exp_d, input int exp_o,
                       input bit guard, input bit wr0);
        int eff, lat, cyc, ea, eb;
        bit seq_ok, done, ec;
        eff = (len > 8) ? 8 : len;
        lat = (eff == 0) ? 1 : eff + 3;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 4'(len);
        if (wr0) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'd0;
            bus.wr_a    = 4'(ma[0]);
            bus.wr_b    = 4'(mb[0]);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        cyc = 0;
        seq_ok = 1'b1;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ec = (eff > 0 && cyc == 1);
            ea = 0;
            eb = 0;
            if (eff > 0 && cyc >= 2 && cyc <= eff + 1) begin
                ea = ma[cyc-2];
                eb = mb[cyc-2];
            end
            if (bus.mac_clr !== ec || bus.mac_a !== 4'(ea) ||
                bus.mac_b !== 4'(eb) || bus.busy !== 1'b1)
                seq_ok = 1'b0;
            if (guard) begin
                bus.start   = (cyc == 3);
                bus.len     = 4'd1;
                bus.wr_en   = (cyc == 3);
                bus.wr_addr = 3'd0;
                bus.wr_a    = 4'd15;
                bus.wr_b    = 4'd15;
            end
            if (bus.res_valid === 1'b1) done = 1'b1;
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("latency", cyc, lat);
        chk("res_data", int'(bus.res_data), exp_d);
        chk("res_ovf", int'(bus.res_ovf), exp_o);
        chk("mac_sequence", int'(seq_ok), 1);
        if (guard) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("hold_valid", int'(bus.res_valid), 1);
                chk("hold_data", int'(bus.res_data), exp_d);
                bus.start = (k == 1);
                bus.wr_en = (k == 1);
            end
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk("release_idle", int'({bus.busy, bus.res_valid}), 0);
        chk("release_keep", int'(bus.res_data), exp_d);
    endtask

    initial begin
        int v1, v2, c2, d1, d2;
        vt[0].a = '{1, 2, 3, 4, 0, 0, 0, 0};
        vt[0].b = '{5, 6, 7, 8, 0, 0, 0, 0};
        vt[0].len = 4; vt[0].d = 70; vt[0].o = 0;
        vt[1].a = '{15, 15, 0, 0, 0, 0, 0, 0};
        vt[1].b = '{15, 15, 0, 0, 0, 0, 0, 0};
        vt[1].len = 2; vt[1].d = 194; vt[1].o = 1;
        vt[2].a = '{1, 2, 3, 4, 5, 6, 7, 8};
        vt[2].b = '{2, 2, 2, 2, 2, 2, 2, 2};
        vt[2].len = 9; vt[2].d = 72; vt[2].o = 0;
        vt[3].a = '{9, 9, 9, 9, 9, 9, 9, 9};
        vt[3].b = '{9, 9, 9, 9, 9, 9, 9, 9};
        vt[3].len = 0; vt[3].d = 0; vt[3].o = 0;
        vt[4].a = '{7, 1, 1, 1, 1, 1, 1, 1};
        vt[4].b = '{9, 1, 1, 1, 1, 1, 1, 1};
        vt[4].len = 1; vt[4].d = 63; vt[4].o = 0;
        vt[5].a = '{15, 15, 15, 15, 15, 15, 15, 15};
        vt[5].b = '{15, 15, 15, 15, 15, 15, 15, 15};
        vt[5].len = 8; vt[5].d = 8; vt[5].o = 1;
        vt[6].a = '{3, 0, 10, 0, 0, 0, 0, 0};
        vt[6].b = '{4, 9, 12, 0, 0, 0, 0, 0};
        vt[6].len = 3; vt[6].d = 132; vt[6].o = 0;
        vt[7].a = '{15, 5, 0, 0, 0, 0, 0, 0};
        vt[7].b = '{15, 6, 0, 0, 0, 0, 0, 0};
        vt[7].len = 2; vt[7].d = 255; vt[7].o = 0;
        vt[8].a = '{15, 5, 1, 0, 0, 0, 0, 0};
        vt[8].b = '{15, 6, 1, 0, 0, 0, 0, 0};
        vt[8].len = 3; vt[8].d = 0; vt[8].o = 1;

        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_a = '0;
        bus.wr_b = '0;
        bus.start = 1'b0;
        bus.len = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            ma = vt[i].a;
            mb = vt[i].b;
            load();
            run(vt[i].len, vt[i].d, vt[i].o, 1'b0, 1'b0);
        end

        // write and start in the same cycle: run sees the new entry 0
        ma = basic_a;
        mb = basic_b;
        load();
        ma[0] = 9;
        mb[0] = 9;
        run(1, 81, 0, 1'b0, 1'b1);

        // busy-time guards with backpressure, then an identical re-run
        ma = basic_a;
        mb = basic_b;
        load();
        run(4, 70, 0, 1'b1, 1'b0);
        run(4, 70, 0, 1'b0, 1'b0);

        // reset during the second ISSUE cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.len = 4'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_mac_a", int'(bus.mac_a), 2);
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        @(negedge clk);
        reset = 1'b1;
        ma = zero8;
        mb = zero8;
        run(4, 0, 0, 1'b0, 1'b0);
        ma = basic_a;
        mb = basic_b;
        load();
        run(4, 70, 0, 1'b0, 1'b0);

        // back-to-back with res_ready tied high
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len = 4'd4;
        @(posedge clk);
        #1;
        bus.len = 4'd2;
        v1 = 0; v2 = 0; c2 = 0; d1 = -1; d2 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mac_clr && c > 1 && c2 == 0) begin
                c2 = c;
                bus.start = 1'b0;
            end
            if (bus.res_valid) begin
                if (v1 == 0) begin
                    v1 = c;
                    d1 = int'(bus.res_data);
                end else if (v2 == 0) begin
                    v2 = c;
                    d2 = int'(bus.res_data);
                end
            end
        end
        bus.start = 1'b0;
        bus.res_ready = 1'b0;
        chk("b2b_first_valid", v1, 7);
        chk("b2b_first_data", d1, 70);
        chk("b2b_second_clr", c2, 9);
        chk("b2b_second_valid", v2, 13);
        chk("b2b_second_data", d2, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
